// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for data_memory_ctrl; stats counters appear only with MEM_STATS_EN.
interface data_memory_ctrl_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
  logic              busy_o;
  logic              err_o;
`ifdef MEM_STATS_EN
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, err_o, rd_cnt_o, wr_cnt_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, err_o, rd_cnt_o, wr_cnt_o
  );
`else
  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, busy_o, err_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, busy_o, err_o
  );
`endif
endinterface

// File: rtl/data_memory_ctrl.sv
// Fixed-latency full-line data memory controller (IDLE/WAIT/ACK).
// Optional read/write ack counters are enabled by defining MEM_STATS_EN.
module data_memory_ctrl #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input logic               clk_i,
  input logic               rst_i,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned TOP_LO = OFF_W + IDX_W;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);
  localparam bit          LAT_ONE = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              err_q;
  logic [LINE_W-1:0] rdata_q;
  logic [LINE_W-1:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic [ADDR_W-1:0] acc_addr;
  logic [LINE_W-1:0] acc_wdata;
  logic              acc_write;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_oor;

  assign accept = (state_q == StIdle) && bus.enable_i;
  // The access happens on the edge that raises ack; with LATENCY=1 that is the accepting edge.
  assign do_access = (accept && LAT_ONE) || ((state_q == StWait) && (cnt_q == 8'd1));

  assign acc_addr  = (state_q == StIdle) ? bus.addr_i  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? bus.data_i  : wdata_q;
  assign acc_write = (state_q == StIdle) ? bus.write_i : write_q;
  assign acc_idx   = acc_addr[OFF_W +: IDX_W];
  assign acc_oor   = (acc_addr >> TOP_LO) != '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = LAT_ONE ? StAck : StWait;
      StWait: if (cnt_q == 8'd1) state_d = StAck;
      StAck:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ack_o  = (state_q == StAck);
    bus.busy_o = (state_q != StIdle);
    bus.err_o  = (state_q == StAck) && err_q;
    bus.data_o = rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= LAT_M1;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.data_i;
        write_q <= bus.write_i;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (do_access) begin
        err_q <= acc_oor;
        if (acc_oor)         rdata_q <= '0;
        else if (!acc_write) rdata_q <= mem[acc_idx];
      end
    end
  end

  // Array has no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_access && acc_write && !acc_oor) mem[acc_idx] <= acc_wdata;
  end

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (do_access && !acc_oor) begin
      if (acc_write && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (!acc_write && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign bus.rd_cnt_o = rd_cnt_q;
  assign bus.wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl with default parameters (LATENCY=10, 32-byte lines).
module tb_data_memory_ctrl;

  localparam int unsigned LAT = 10;

  typedef struct {
    string          tag;
    int unsigned    cyc;
    bit             err;
    bit             wr;
    logic [255:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.LINE_W(256), .ADDR_W(32)) bus ();

  data_memory_ctrl #(
    .LINE_W (256),
    .ADDR_W (32),
    .DEPTH  (512),
    .LATENCY(LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int unsigned  pe = 0;
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  int unsigned  ack_total = 0;
  int unsigned  exp_rd = 0;
  int unsigned  exp_wr = 0;
  exp_t         sb[$];
  logic [255:0] model [int];
  logic [255:0] last_rd = '0;

  always @(posedge clk) pe <= pe + 1;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ack_o) begin
      ack_total++;
      if (sb.size() == 0) begin
        check_eq("unexpected_ack", 256'(bus.ack_o), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq({e.tag, "_cycle"}, 256'(pe), 256'(e.cyc));
        check_eq({e.tag, "_err"}, 256'(bus.err_o), 256'(e.err));
        check_eq({e.tag, "_data"}, bus.data_o, e.data);
        if (!e.err) begin
          if (e.wr) exp_wr++;
          else      exp_rd++;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o) check_eq("idle_timeout", 256'(bus.busy_o), 256'(0));
  endtask

  function automatic exp_t predict(input string tag, input bit wr, input logic [31:0] addr,
                                   input logic [255:0] d, input int unsigned cyc);
    exp_t e;
    int   idx;
    bit   oor;
    idx   = int'(addr[13:5]);
    oor   = (addr[31:14] != 18'd0);
    e.tag = tag;
    e.cyc = cyc;
    e.err = oor;
    e.wr  = wr;
    if (oor) begin
      e.data  = '0;
      last_rd = '0;
    end else if (wr) begin
      e.data     = last_rd;
      model[idx] = d;
    end else begin
      e.data  = model[idx];
      last_rd = e.data;
    end
    return e;
  endfunction

  task automatic issue(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [255:0] d);
    wait_idle();
    sb.push_back(predict(tag, wr, addr, d, pe + LAT));
    bus.addr_i   = addr;
    bus.data_i   = d;
    bus.write_i  = wr;
    bus.enable_i = 1'b1;
    @(negedge clk);
    bus.enable_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    int unsigned base;
    int unsigned a0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    bus.write_i  = 1'b0;
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 256'(bus.ack_o), 256'(0));
    check_eq("rst_busy", 256'(bus.busy_o), 256'(0));
    check_eq("rst_err", 256'(bus.err_o), 256'(0));
    check_eq("rst_data", bus.data_o, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    issue("wr_0", 1'b1, 32'h0000_0000, 256'h5);
    issue("rd_0", 1'b0, 32'h0000_0000, '0);
    issue("wr_400", 1'b1, 32'h0000_0400, 256'hAB);
    issue("rd_400", 1'b0, 32'h0000_0400, '0);
    issue("rd_41f_offset", 1'b0, 32'h0000_041F, '0);
    issue("wr_3fe0", 1'b1, 32'h0000_3FE0, {8{32'hDEAD_BEEF}});
    issue("rd_3fff_last", 1'b0, 32'h0000_3FFF, '0);
    issue("wr_4000_err", 1'b1, 32'h0000_4000, 256'h77);
    issue("rd_3fe0_after_err", 1'b0, 32'h0000_3FE0, '0);
    issue("rd_4000_err", 1'b0, 32'h0000_4000, '0);
    issue("rd_0_after_err", 1'b0, 32'h0000_0000, '0);
    issue("wr_20", 1'b1, 32'h0000_0020, {4{64'h0123_4567_89AB_CDEF}});
    drain("drain_basic");

    // enable held for 25 cycles: two acks inside the window, a third request lands at cycle 22
    wait_idle();
    base = pe;
    sb.push_back(predict("hold_a", 1'b0, 32'h0000_0400, '0, base + 10));
    sb.push_back(predict("hold_b", 1'b0, 32'h0000_0400, '0, base + 21));
    sb.push_back(predict("hold_c", 1'b0, 32'h0000_0400, '0, base + 32));
    a0 = ack_total;
    bus.addr_i   = 32'h0000_0400;
    bus.write_i  = 1'b0;
    bus.enable_i = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("hold_acks", 256'(ack_total - a0), 256'(2));
    bus.enable_i = 1'b0;
    drain("drain_hold");
    @(negedge clk);

`ifdef MEM_STATS_EN
    check_eq("pre_rst_rd_cnt", 256'(bus.rd_cnt_o), 256'(exp_rd));
    check_eq("pre_rst_wr_cnt", 256'(bus.wr_cnt_o), 256'(exp_wr));
`endif

    // reset at cycle 5 of a write to 0x20 aborts it
    wait_idle();
    bus.addr_i   = 32'h0000_0020;
    bus.data_i   = 256'hBAD;
    bus.write_i  = 1'b1;
    bus.enable_i = 1'b1;
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    exp_rd  = 0;
    exp_wr  = 0;
    check_eq("abort_busy", 256'(bus.busy_o), 256'(0));
    check_eq("abort_ack", 256'(bus.ack_o), 256'(0));
    check_eq("abort_data", bus.data_o, 256'(0));
    repeat (12) @(negedge clk);
    check_eq("abort_no_ack", 256'(ack_total - a0), 256'(3));

    issue("rd_20_after_abort", 1'b0, 32'h0000_0020, '0);
    issue("wr_3fe0_b", 1'b1, 32'h0000_3FE0, 256'h1234_5678);
    issue("rd_3fe0_b", 1'b0, 32'h0000_3FE0, '0);
    issue("wr_40", 1'b1, 32'h0000_0040, {32{8'h5A}});
    issue("rd_err_high", 1'b0, 32'h8000_0000, '0);
    issue("rd_40", 1'b0, 32'h0000_0040, '0);
    drain("drain_final");
    @(negedge clk);

`ifdef MEM_STATS_EN
    check_eq("rd_cnt", 256'(bus.rd_cnt_o), 256'(3));
    check_eq("wr_cnt", 256'(bus.wr_cnt_o), 256'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning line data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter DEPTH, default 512, meaning number of lines (power of two).
REQ-004 The block SHALL have parameter LATENCY, default 10, meaning cycles from request accept to ack (range 1..255).
REQ-005 The block SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port addr_i, input, ADDR_W bits: byte address; line index = addr_i[log2(LINE_W/8) +: log2(DEPTH)].
REQ-008 The block SHALL have port data_i, input, LINE_W bits: write line data.
REQ-009 The block SHALL have port enable_i, input, 1 bit: request valid.
REQ-010 The block SHALL have port write_i, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have port ack_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port data_o, output, LINE_W bits: read line data.
REQ-013 The block SHALL have port busy_o, output, 1 bit: high while a request is in flight.
REQ-014 The block SHALL have port err_o, output, 1 bit: qualifies ack_o; set when the address is out of range.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and ACK.
REQ-016 In IDLE, on enable_i=1, the block SHALL latch addr_i, data_i and write_i, load the latency counter with LATENCY-1, and enter WAIT (or ACK directly if LATENCY=1).
REQ-017 In WAIT, the counter SHALL decrement each cycle; at 0 the access SHALL be performed and the FSM SHALL enter ACK.
REQ-018 ack_o SHALL be high for exactly one cycle, first high LATENCY cycles after the accepting edge; the FSM SHALL return to IDLE the next cycle.
REQ-019 busy_o SHALL be high in WAIT and ACK and low in IDLE.
REQ-020 enable_i and the request inputs SHALL be ignored in WAIT and ACK; a request held high through ACK SHALL NOT be re-accepted until IDLE.
REQ-021 A write SHALL update the memory at the same edge on which ack_o rises; a read SHALL present the line on data_o in the ack cycle.
REQ-022 data_o SHALL hold the last read value until the next read ack; writes SHALL NOT change data_o.
REQ-023 An address with nonzero bits above the index field SHALL set err_o with ack_o, suppress the write, and return data_o = 0.
REQ-024 Byte-offset bits below the index field SHALL be ignored; accesses SHALL be full-line only.

Reset
REQ-025 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE and ack_o, busy_o, err_o and data_o SHALL be 0.
REQ-026 A reset asserted mid-request SHALL abort the request with no memory write and no ack.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro MEM_STATS_EN defined, the block SHALL add 32-bit outputs rd_cnt_o and wr_cnt_o, each incremented on every read/write ack (error acks excluded), saturating at 0xFFFFFFFF and reset to 0.
REQ-029 Without MEM_STATS_EN, these ports and their counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-030 Read with LATENCY=10, memory[0]=0x5, addr 0x0 accepted at cycle 0 -> ack_o=1 only in cycle 10, data_o=0x5, err_o=0.
REQ-031 Write of 0xAB at addr 0x400, then a read of 0x400 -> second ack returns 0xAB; memory[32]=0xAB.
REQ-032 enable_i held high for 25 cycles, LATENCY=10 -> exactly two acks, at cycles 10 and 21.
REQ-033 Write to addr 0x4000 (DEPTH=512, 32-byte lines) -> ack_o=1 with err_o=1, memory unchanged, data_o=0.
REQ-034 rst_i pulsed at cycle 5 of a write to 0x20 -> no ack, memory[1] unchanged, busy_o=0 after reset.
REQ-035 With MEM_STATS_EN: 3 reads, 2 writes and 1 error -> rd_cnt_o=3, wr_cnt_o=2.
